// File: rtl/hull_alarm_controller_if.sv
// ============================================================================
// hull_alarm_controller_if : status inputs and alarm/request outputs  (rev 1.0)
// ============================================================================
`default_nettype none

interface hull_alarm_controller_if #(
  parameter int N = 32
);
  logic [N-1:0] shield;
  logic [N-1:0] temp;
  logic [N-1:0] power;
  logic [N-1:0] o2;
  logic         fatal;
  logic         ack;
  logic [2:0]   level;
  logic         o2sup_req;
  logic         chrg_req;
  logic [3:0]   mode_req;
  logic         abort;
  logic [15:0]  countdown;

  modport master (
    output shield, temp, power, o2, fatal, ack,
    input  level, o2sup_req, chrg_req, mode_req, abort, countdown
  );

  modport slave (
    input  shield, temp, power, o2, fatal, ack,
    output level, o2sup_req, chrg_req, mode_req, abort, countdown
  );
endinterface

`default_nettype wire

// File: rtl/hull_alarm_controller.sv
// ============================================================================
// hull_alarm_controller : debounced alarm grading, requests, abort countdown (rev 1.0)
// ============================================================================
`default_nettype none

module hull_alarm_controller #(
  parameter int unsigned TEMP_CAUTION = 80,
  parameter int unsigned TEMP_WARN    = 95,
  parameter int unsigned O2_CAUTION   = 50,
  parameter int unsigned O2_WARN      = 20,
  parameter int unsigned PWR_CAUTION  = 30,
  parameter int unsigned SH_CAUTION   = 60,
  parameter int unsigned SH_WARN      = 25,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned HOLD         = 8,
  parameter int unsigned ABORT_CNT    = 16
) (
  input  wire logic              clk,
  input  wire logic              rst,
  hull_alarm_controller_if.slave bus
);

  typedef enum logic [2:0] {
    NOMINAL  = 3'd0,
    CAUTION  = 3'd1,
    WARNING  = 3'd2,
    CRITICAL = 3'd3,
    ABORT    = 3'd4
  } state_t;

  localparam logic [15:0] c_abort_cnt = 16'(ABORT_CNT);
  localparam logic [7:0]  c_esc_last  = 8'(DEBOUNCE - 1);
  localparam logic [7:0]  c_clr_last  = 8'(HOLD - 1);

  state_t      state;
  logic [7:0]  esc_cnt;
  logic [7:0]  clr_cnt;
  logic [15:0] countdown;
  logic        abort_r;
  logic        o2sup_r;
  logic        chrg_r;
  logic [3:0]  mode_r;
  logic [2:0]  sev;

  always_comb begin
    sev = 3'd0;
    if (bus.fatal || bus.o2 == '0)
      sev = 3'd3;
    else if (bus.temp >= TEMP_WARN || bus.o2 < O2_WARN || bus.power == '0 ||
             bus.shield < SH_WARN)
      sev = 3'd2;
    else if (bus.temp >= TEMP_CAUTION || bus.o2 < O2_CAUTION ||
             bus.power < PWR_CAUTION || bus.shield < SH_CAUTION)
      sev = 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NOMINAL;
      esc_cnt   <= '0;
      clr_cnt   <= '0;
      countdown <= c_abort_cnt;
      abort_r   <= 1'b0;
      o2sup_r   <= 1'b0;
      chrg_r    <= 1'b0;
      mode_r    <= 4'b0000;
    end else begin
      // Requests track the inputs everywhere except the terminal state.
      if (state == ABORT) begin
        o2sup_r <= 1'b0;
        chrg_r  <= 1'b0;
        mode_r  <= 4'b0000;
      end else begin
        o2sup_r <= (bus.o2 < O2_CAUTION);
        chrg_r  <= (bus.power < PWR_CAUTION);
        mode_r  <= (bus.shield < SH_CAUTION && bus.power != '0) ? 4'b0100 : 4'b0000;
      end

      case (state)
        ABORT: begin
          abort_r   <= 1'b1;
          countdown <= '0;
        end
        CRITICAL: begin
          esc_cnt <= '0;
          clr_cnt <= '0;
          // A valid ack takes priority over the final countdown tick.
          if (bus.ack && !bus.fatal) begin
            state     <= WARNING;
            countdown <= c_abort_cnt;
          end else if (countdown == 16'd1) begin
            state     <= ABORT;
            abort_r   <= 1'b1;
            countdown <= '0;
          end else begin
            countdown <= countdown - 16'd1;
          end
        end
        default: begin
          countdown <= c_abort_cnt;
          if (sev == 3'd3) begin
            state   <= CRITICAL;
            esc_cnt <= '0;
            clr_cnt <= '0;
          end else if (sev > state) begin
            clr_cnt <= '0;
            if (esc_cnt == c_esc_last) begin
              state   <= state_t'(sev);
              esc_cnt <= '0;
            end else begin
              esc_cnt <= esc_cnt + 8'd1;
            end
          end else if (sev < state) begin
            esc_cnt <= '0;
            if (clr_cnt == c_clr_last) begin
              state   <= state_t'(state - 3'd1);
              clr_cnt <= '0;
            end else begin
              clr_cnt <= clr_cnt + 8'd1;
            end
          end else begin
            esc_cnt <= '0;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign bus.level     = state;
  assign bus.o2sup_req = o2sup_r;
  assign bus.chrg_req  = chrg_r;
  assign bus.mode_req  = mode_r;
  assign bus.abort     = abort_r;
  assign bus.countdown = countdown;

endmodule

`default_nettype wire

// File: tb/tb_hull_alarm_controller.sv
// ============================================================================
// tb_hull_alarm_controller : scoreboard bench for hull_alarm_controller (rev 1.0)
// ============================================================================
`default_nettype none

module tb_hull_alarm_controller;

  typedef struct packed {
    logic [2:0]  level;
    logic        o2sup;
    logic        chrg;
    logic [3:0]  mode;
    logic        abort;
    logic [15:0] cd;
  } snap_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  snap_t sb[$];
  snap_t got;
  snap_t want;

  hull_alarm_controller_if #(.N(32)) bus ();

  hull_alarm_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [2:0] lvl, input logic o2s, input logic ch,
                               input logic [3:0] md, input logic ab, input logic [15:0] cd);
    snap_t s;
    s.level = lvl; s.o2sup = o2s; s.chrg = ch; s.mode = md; s.abort = ab; s.cd = cd;
    return s;
  endfunction

  function automatic snap_t observe();
    return mk(bus.level, bus.o2sup_req, bus.chrg_req, bus.mode_req, bus.abort, bus.countdown);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nominal();
    bus.temp = 32'd20; bus.o2 = 32'd100; bus.power = 32'd100; bus.shield = 32'd100;
    bus.fatal = 1'b0; bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    nominal();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sb.push_back(mk(3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL reset_state: got=%h want=%h", got, want);
    end
    for (int i = 0; i < 20; i++) begin
      bus.ack = (i == 10);
      sb.push_back(mk(3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL nominal[%0d]: got=%h want=%h", i, got, want);
      end
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_caution_debounce();
    for (int i = 0; i < 4; i++) begin
      bus.temp = (i < 3) ? 32'd85 : 32'd20;
      sb.push_back(mk(3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL short_caution[%0d]: got=%h want=%h", i, got, want);
      end
    end
    bus.temp = 32'd85;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk((i >= 3) ? 3'd1 : 3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL caution_escalate[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_escalation();
    bus.temp = 32'd20; bus.shield = 32'd20; bus.power = 32'd50;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk((i == 3) ? 3'd2 : 3'd1, 1'b0, 1'b0, 4'b0100, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL warn_escalate[%0d]: got=%h want=%h", i, got, want);
      end
    end
    bus.power = 32'd0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(3'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL power_zero[%0d]: got=%h want=%h", i, got, want);
      end
    end
  endtask

  task automatic test_deescalation();
    nominal();
    for (int i = 0; i < 8; i++) begin
      sb.push_back(mk((i == 7) ? 3'd1 : 3'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL deesc_2to1[%0d]: got=%h want=%h", i, got, want);
      end
    end
    // Glitch on the 5th cycle of the hold restarts the count.
    for (int i = 0; i < 13; i++) begin
      bus.temp = (i == 4) ? 32'd85 : 32'd20;
      sb.push_back(mk((i == 12) ? 3'd0 : 3'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL deesc_glitch[%0d]: got=%h want=%h", i, got, want);
      end
    end
    bus.temp = 32'd20;
  endtask

  task automatic test_critical_ack();
    for (int i = 0; i < 9; i++) begin
      bus.fatal = (i == 0);
      bus.ack   = (i == 7);
      if (i == 0)      sb.push_back(mk(3'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
      else if (i < 7)  sb.push_back(mk(3'd3, 1'b0, 1'b0, 4'b0000, 1'b0, 16'(16 - i)));
      else             sb.push_back(mk(3'd2, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL critical_ack[%0d]: got=%h want=%h", i, got, want);
      end
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_abort();
    bus.fatal = 1'b1; bus.o2 = 32'd40;
    for (int i = 0; i < 18; i++) begin
      bus.ack = (i == 4);
      if (i == 0)       sb.push_back(mk(3'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 16'd16));
      else if (i < 16)  sb.push_back(mk(3'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 16'(16 - i)));
      else if (i == 16) sb.push_back(mk(3'd4, 1'b1, 1'b0, 4'b0000, 1'b1, 16'd0));
      else              sb.push_back(mk(3'd4, 1'b0, 1'b0, 4'b0000, 1'b1, 16'd0));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL abort_countdown[%0d]: got=%h want=%h", i, got, want);
      end
    end
    nominal();
    for (int i = 0; i < 3; i++) begin
      bus.ack = (i == 0);
      sb.push_back(mk(3'd4, 1'b0, 1'b0, 4'b0000, 1'b1, 16'd0));
      tick();
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL abort_sticky[%0d]: got=%h want=%h", i, got, want);
      end
    end
    bus.ack = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    sb.push_back(mk(3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL async_reset: got=%h want=%h", got, want);
    end
    tick();
    rst = 1'b0;
    sb.push_back(mk(3'd0, 1'b0, 1'b0, 4'b0000, 1'b0, 16'd16));
    tick();
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL post_reset: got=%h want=%h", got, want);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    nominal();
    test_reset();
    test_caution_debounce();
    test_escalation();
    test_deescalation();
    test_critical_ack();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
